// File: rtl/prog_loader_if.sv
// Byte-stream and program-RAM write signals of the program loader.
// The upstream source, RAM and processor use master; the loader uses slave.
interface prog_loader_if #(
    parameter int ADDR_W = 7
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_din;
    logic              start;
    logic              load_done;
    logic              load_error;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, ram_write_en, ram_addr, ram_din, start, load_done, load_error
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, ram_write_en, ram_addr, ram_din, start, load_done, load_error
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a framed program image (N, N big-endian words, XOR checksum) into program RAM
// and releases the processor only after the checksum matches.
module prog_loader #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input logic         clk,
    input logic         rst_n,
    prog_loader_if.slave bus
);
    // HDR header | HI/LO word bytes | WRITE RAM strobe | CSUM checksum | DONE/ERR sticky
    typedef enum logic [2:0] {
        S_HDR, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       din_q, din_d;
    logic              accept;
    logic [7:0]        cnt_inc;

    // Ready is forced low while reset is held so nothing is taken during reset.
    assign bus.byte_ready   = rst_n && (state_q inside {S_HDR, S_HI, S_LO, S_CSUM});
    assign accept           = bus.byte_valid && bus.byte_ready;
    assign cnt_inc          = cnt_q + 8'd1;

    assign bus.ram_write_en = (state_q == S_WRITE);
    assign bus.ram_addr     = addr_q;
    assign bus.ram_din      = din_q;
    assign bus.start        = (state_q == S_DONE);
    assign bus.load_done    = (state_q == S_DONE);
    assign bus.load_error   = (state_q == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HDR;
            n_q     <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            S_HDR: begin
                if (accept) begin
                    n_d = bus.byte_data;
                    if (bus.byte_data == 8'd0 || bus.byte_data > DEPTH_B) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d   = '0;
                        csum_d  = '0;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = bus.byte_data;
                    csum_d  = csum_q ^ bus.byte_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    csum_d  = csum_q ^ bus.byte_data;
                    din_d   = {hi_q, bus.byte_data};
                    addr_d  = cnt_q[ADDR_W-1:0];
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == n_q) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized and directed frames against a frame-level model of the loader.
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(7)) bus ();

    prog_loader #(.ADDR_W(7), .DEPTH(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [22:0] wq[$];
    logic [15:0] ram_seen[128];
    bit          exp_start = 1'b0;
    bit          exp_err = 1'b0;
    int          lo_acc_cnt = 0;
    int          write_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model's expectations.
    initial begin : compare
        int last_lo;
        logic [22:0] e;
        last_lo = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("write_en", 32'(bus.ram_write_en), 32'(lo_acc_cnt != last_lo));
                if (bus.ram_write_en) begin
                    write_count++;
                    check("ready_in_write", 32'(bus.byte_ready), 32'd0);
                    check("write_expected", 32'(wq.size() != 0), 32'd1);
                    if (wq.size() != 0) begin
                        e = wq.pop_front();
                        check("write_addr", 32'(bus.ram_addr), 32'(e[22:16]));
                        check("write_data", 32'(bus.ram_din), 32'(e[15:0]));
                    end
                    ram_seen[bus.ram_addr] = bus.ram_din;
                end
                check("start", 32'(bus.start), 32'(exp_start));
                check("load_done", 32'(bus.load_done), 32'(exp_start));
                check("load_error", 32'(bus.load_error), 32'(exp_err));
                if (exp_err) check("ready_in_err", 32'(bus.byte_ready), 32'd0);
            end
            last_lo = lo_acc_cnt;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'({bus.byte_ready, bus.ram_write_en, bus.ram_addr, bus.ram_din,
                                    bus.start, bus.load_done, bus.load_error}), 32'd0);
        bus.byte_valid = 1'b0;
        wq.delete();
        exp_start = 1'b0;
        exp_err = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data = b;
        @(negedge clk);
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = bus.byte_ready;
        if (!ok) begin
            check("accept_timeout", 32'(ok), 32'd1);
            bus.byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic make_frame(input int n, input bit corrupt, input bit idx_data,
                              output logic [7:0] fr[$]);
        logic [7:0] x;
        logic [7:0] hi;
        logic [7:0] lo;
        x = 8'd0;
        fr.delete();
        fr.push_back(8'(n));
        if (n <= 128) begin
            for (int i = 0; i < n; i++) begin
                hi = idx_data ? 8'(i >> 8) : 8'($urandom_range(0, 255));
                lo = idx_data ? 8'(i) : 8'($urandom_range(0, 255));
                fr.push_back(hi);
                fr.push_back(lo);
                x ^= hi ^ lo;
            end
        end
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
    endtask

    // Model: derive writes and outcome from the frame bytes, then drive them.
    task automatic run_frame(input logic [7:0] fr[$], input int nsend, input bit hold);
        int  n;
        int  nbytes;
        int  gap;
        bit  hdr_ok;
        bit  good;
        bit  ok;
        logic [7:0] x;
        n = int'(fr[0]);
        hdr_ok = (n != 0) && (n <= 128);
        good = 1'b0;
        x = 8'd0;
        if (hdr_ok) begin
            for (int i = 0; i < n; i++) begin
                wq.push_back({7'(i), fr[1 + 2 * i], fr[2 + 2 * i]});
                x ^= fr[1 + 2 * i] ^ fr[2 + 2 * i];
            end
            good = (fr[2 * n + 1] == x);
        end
        nbytes = hdr_ok ? 2 * n + 2 : 1;
        if (nsend >= 0 && nsend < nbytes) nbytes = nsend;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(fr[i], ok);
            if (!ok) break;
            if (i >= 1 && i <= 2 * n && (i % 2) == 0) lo_acc_cnt++;
            if (i == 0 && !hdr_ok) exp_err = 1'b1;
            if (hdr_ok && i == 2 * n + 1) begin
                if (good) exp_start = 1'b1;
                else exp_err = 1'b1;
            end
            if (!hold) begin
                gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    bus.byte_valid = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
            end
        end
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (nsend < 0) check("writes_drained", 32'(wq.size()), 32'd0);
    endtask

    initial begin : stim
        logic [7:0] fr[$];
        int wc;
        int n;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'd0;
        #3;
        do_reset();

        fr = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run_frame(fr, -1, 1'b0);
        check("good2_addr0", 32'(ram_seen[0]), 32'h1234);
        check("good2_addr1", 32'(ram_seen[1]), 32'hABCD);
        check("good2_start", 32'(bus.start), 32'd1);
        check("good2_error", 32'(bus.load_error), 32'd0);

        do_reset();
        ram_seen[0] = 16'h0;
        ram_seen[1] = 16'h0;
        fr = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        run_frame(fr, -1, 1'b0);
        check("badchk_addr1", 32'(ram_seen[1]), 32'hABCD);
        check("badchk_error", 32'(bus.load_error), 32'd1);
        check("badchk_start", 32'(bus.start), 32'd0);
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;

        foreach (fr[i]) fr[i] = 8'h00;
        do_reset();
        wc = write_count;
        fr = '{8'h00};
        run_frame(fr, -1, 1'b0);
        check("hdr00_error", 32'(bus.load_error), 32'd1);
        check("hdr00_nowrite", 32'(write_count - wc), 32'd0);

        do_reset();
        wc = write_count;
        fr = '{8'h81};
        run_frame(fr, -1, 1'b0);
        check("hdr81_error", 32'(bus.load_error), 32'd1);
        check("hdr81_nowrite", 32'(write_count - wc), 32'd0);

        do_reset();
        wc = write_count;
        make_frame(128, 1'b0, 1'b1, fr);
        run_frame(fr, -1, 1'b0);
        check("n128_last", 32'(ram_seen[127]), 32'h007F);
        check("n128_writes", 32'(write_count - wc), 32'd128);
        check("n128_done", 32'(bus.load_done), 32'd1);

        do_reset();
        make_frame(3, 1'b0, 1'b0, fr);
        run_frame(fr, -1, 1'b1);
        check("hold3_done", 32'(bus.load_done), 32'd1);

        do_reset();
        make_frame(4, 1'b0, 1'b0, fr);
        run_frame(fr, 4, 1'b0);
        do_reset();
        ram_seen[0] = 16'h0;
        fr = '{8'h01, 8'h3C, 8'h00, 8'h3C};
        run_frame(fr, -1, 1'b0);
        check("reload_addr0", 32'(ram_seen[0]), 32'h3C00);
        check("reload_start", 32'(bus.start), 32'd1);

        for (int k = 0; k < 20; k++) begin
            do_reset();
            if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(129, 255));
            else n = int'($urandom_range(1, 12));
            make_frame(n, ($urandom_range(0, 3) == 0), 1'b0, fr);
            run_frame(fr, -1, ($urandom_range(0, 1) == 1));
        end
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
